// File: rtl/systolic_seq_ctrl_if.sv
// Control bundle shared by the tile scheduler, systolic_seq_ctrl and the PE grid.
// master = scheduler side (drives start/k_len/abort), slave = sequencer side.
interface systolic_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 16,
    parameter int RW = (N > 1) ? $clog2(N) : 1
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          acc_clear;
    logic          feed_valid;
    logic [KW-1:0] k_idx;
    logic [N-1:0]  row_valid;
    logic [N-1:0]  col_valid;
    logic          drain_en;
    logic [RW-1:0] drain_row;
    logic [31:0]   perf_cycles;

    modport master (
        output start, k_len, abort,
        input  busy, done, acc_clear, feed_valid, k_idx, row_valid, col_valid,
               drain_en, drain_row, perf_cycles
    );

    modport slave (
        input  start, k_len, abort,
        output busy, done, acc_clear, feed_valid, k_idx, row_valid, col_valid,
               drain_en, drain_row, perf_cycles
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: clear, skewed feed, flush, drain, done.
// Optional run-length counter on perf_cycles when SEQ_CTRL_PERF_EN is defined.
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int KW = 16,
    parameter int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int            FW         = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
    localparam logic [RW-1:0] DRAIN_LAST = RW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          run_end;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_idx_q;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] drain_row_q;
    logic [N-1:0]  lane_vld;
    logic          busy_q;
    logic          done_q;
    logic          acc_clear_q;
    logic          drain_en_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (k_len_q == '0) ? S_FLUSH : S_FEED;
            S_FEED:  if (k_idx_q == k_len_q - KW'(1)) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_row_q == DRAIN_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // abort overrides everything, including a start seen in IDLE
        if (bus.abort) state_nxt = S_IDLE;
    end

    assign accept  = (state == S_IDLE) && bus.start && !bus.abort;
    assign run_end = (state == S_DRAIN) && (state_nxt == S_IDLE) && !bus.abort;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) k_len_q <= bus.k_len;
    end

    // Output stage: all strobes are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_clear_q <= 1'b0;
            drain_en_q  <= 1'b0;
            lane_vld    <= '0;
            k_idx_q     <= '0;
            flush_cnt   <= '0;
            drain_row_q <= '0;
        end else begin
            busy_q      <= (state_nxt != S_IDLE);
            done_q      <= run_end;
            acc_clear_q <= (state_nxt == S_CLEAR);
            drain_en_q  <= (state_nxt == S_DRAIN);

            // lane i sees feed_valid delayed by i cycles; abort empties the chain
            lane_vld[0] <= (state_nxt == S_FEED);
            for (int i = 1; i < N; i++) begin
                lane_vld[i] <= lane_vld[i-1] && !bus.abort;
            end

            if (bus.abort && (state != S_IDLE)) begin
                k_idx_q <= '0;
            end else if (state_nxt == S_FEED) begin
                k_idx_q <= (state == S_FEED) ? k_idx_q + KW'(1) : '0;
            end

            flush_cnt   <= ((state_nxt == S_FLUSH) && (state == S_FLUSH)) ? flush_cnt + FW'(1) : '0;
            drain_row_q <= ((state_nxt == S_DRAIN) && (state == S_DRAIN)) ? drain_row_q + RW'(1) : '0;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.acc_clear  = acc_clear_q;
    assign bus.feed_valid = lane_vld[0];
    assign bus.k_idx      = k_idx_q;
    assign bus.row_valid  = lane_vld;
    assign bus.col_valid  = lane_vld;
    assign bus.drain_en   = drain_en_q;
    assign bus.drain_row  = drain_row_q;

`ifdef SEQ_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_q;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // perf_cnt holds busy cycles so far; the published value adds the
    // current busy cycle and the done cycle that follows it
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
            perf_q   <= '0;
        end else begin
            if (accept)      perf_cnt <= '0;
            else if (busy_q) perf_cnt <= sat_add(perf_cnt, 2'd1);
            if (run_end)     perf_q   <= sat_add(perf_cnt, 2'd2);
        end
    end

    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: per-cycle expected outputs are queued when a run
// is started and popped/compared every cycle; a second N=1 instance covers the small-array case.
module tb_systolic_seq_ctrl;
    localparam int N  = 4;
    localparam int KW = 8;
    localparam int RW = 2;
`ifdef SEQ_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          acc_clear;
        logic          feed_valid;
        logic [KW-1:0] k_idx;
        logic [N-1:0]  row_valid;
        logic [N-1:0]  col_valid;
        logic          drain_en;
        logic [RW-1:0] drain_row;
        logic [31:0]   perf;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    systolic_seq_ctrl_if #(.N(N), .KW(KW)) bus ();
    systolic_seq_ctrl_if #(.N(1), .KW(KW)) bus1 ();

    systolic_seq_ctrl #(.N(N), .KW(KW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_seq_ctrl #(.N(1), .KW(KW)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    obs_t          exp_q[$];
    logic [KW-1:0] model_kidx = '0;
    logic [31:0]   model_perf = '0;
    int            n_assert   = 0;
    int            n_fail     = 0;
    int            cyc        = 0;

    function automatic obs_t idle_obs();
        obs_t r;
        r       = '0;
        r.k_idx = model_kidx;
        r.perf  = model_perf;
        return r;
    endfunction

    // Expected outputs for cycles 1..K+3N+1 after a start accepted now
    task automatic push_run(input int k);
        obs_t          r;
        logic [KW-1:0] kk;
        int            last;
        last = k + 3 * N + 1;
        kk   = model_kidx;
        for (int t = 1; t <= last; t++) begin
            r            = '0;
            r.busy       = (t <= k + 3 * N);
            r.done       = (t == last);
            r.acc_clear  = (t == 1);
            r.feed_valid = (t >= 2) && (t <= k + 1);
            if (r.feed_valid) kk = KW'(t - 2);
            r.k_idx = kk;
            for (int i = 0; i < N; i++) begin
                r.row_valid[i] = (t >= 2 + i) && (t <= k + 1 + i);
            end
            r.col_valid = r.row_valid;
            r.drain_en  = (t >= k + 2 * N + 1) && (t <= k + 3 * N);
            r.drain_row = r.drain_en ? RW'(t - (k + 2 * N + 1)) : '0;
            if (t == last) r.perf = PERF_ON ? 32'(last) : 32'd0;
            else           r.perf = model_perf;
            exp_q.push_back(r);
        end
    endtask

    task automatic tick(input string tag);
        obs_t e;
        obs_t o;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = idle_obs();
        model_kidx = e.k_idx;
        model_perf = e.perf;
        o.busy       = bus.busy;
        o.done       = bus.done;
        o.acc_clear  = bus.acc_clear;
        o.feed_valid = bus.feed_valid;
        o.k_idx      = bus.k_idx;
        o.row_valid  = bus.row_valid;
        o.col_valid  = bus.col_valid;
        o.drain_en   = bus.drain_en;
        o.drain_row  = bus.drain_row;
        o.perf       = bus.perf_cycles;
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, o, e);
        end
        cyc++;
    endtask

    initial begin
        logic [5:0] o1;
        logic [5:0] e1;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        bus.abort   = 1'b0;
        bus1.start  = 1'b0;
        bus1.k_len  = '0;
        bus1.abort  = 1'b0;

        // reset state
        repeat (3) tick("reset");
        rst = 1'b0;
        repeat (2) tick("idle");

        // K=3 run
        bus.k_len = 8'd3;
        bus.start = 1'b1;
        push_run(3);
        tick("k3");
        bus.start = 1'b0;
        repeat (15) tick("k3");
        repeat (2) tick("k3_after");

        // K=0 run
        bus.k_len = 8'd0;
        bus.start = 1'b1;
        push_run(0);
        tick("k0");
        bus.start = 1'b0;
        repeat (12) tick("k0");
        tick("k0_after");

        // start held high: back-to-back K=2 runs, accepted in the done cycle
        bus.k_len = 8'd2;
        bus.start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_run(2);
            repeat (15) tick("b2b");
        end
        bus.start = 1'b0;
        repeat (2) tick("b2b_after");

        // start with a different k_len during FLUSH is ignored
        bus.k_len = 8'd2;
        bus.start = 1'b1;
        push_run(2);
        tick("flush_start");
        bus.start = 1'b0;
        repeat (5) tick("flush_start");
        bus.start = 1'b1;
        bus.k_len = 8'd7;
        repeat (2) tick("flush_start");
        bus.start = 1'b0;
        repeat (7) tick("flush_start");
        tick("flush_start_after");

        // abort at cycle 3 of a K=5 run
        bus.k_len = 8'd5;
        bus.start = 1'b1;
        push_run(5);
        tick("abort_run");
        bus.start = 1'b0;
        repeat (2) tick("abort_run");
        bus.abort = 1'b1;
        exp_q.delete();
        model_kidx = '0;
        tick("abort_next");
        bus.abort = 1'b0;
        repeat (12) tick("abort_quiet");

        // abort together with start in IDLE
        bus.k_len = 8'd4;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick("abort_start");
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) tick("abort_start");

        // rst during DRAIN, then a K=1 run
        bus.k_len = 8'd2;
        bus.start = 1'b1;
        push_run(2);
        tick("rst_run");
        bus.start = 1'b0;
        repeat (11) tick("rst_run");
        rst = 1'b1;
        exp_q.delete();
        model_kidx = '0;
        model_perf = '0;
        tick("rst_next");
        rst = 1'b0;
        tick("rst_idle");
        bus.k_len = 8'd1;
        bus.start = 1'b1;
        push_run(1);
        tick("k1");
        bus.start = 1'b0;
        repeat (13) tick("k1");

        // maximum K: k_idx must reach K-1 without wrapping
        bus.k_len = 8'd255;
        bus.start = 1'b1;
        push_run(255);
        tick("kmax");
        bus.start = 1'b0;
        repeat (267) tick("kmax");
        tick("kmax_after");

        // N=1 instance, K=2: clear 1, feed 2..3, flush 4, drain 5, done 6
        bus1.k_len = 8'd2;
        bus1.start = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick("n1_main_idle");
            bus1.start = 1'b0;
            e1 = {t == 1, (t >= 2) && (t <= 3), (t >= 2) && (t <= 3), t == 5, t == 6, t <= 5};
            o1 = {bus1.acc_clear, bus1.feed_valid, bus1.row_valid[0], bus1.drain_en, bus1.done, bus1.busy};
            n_assert++;
            assert (o1 === e1) else begin
                n_fail++;
                $error("FAIL n1 cycle %0d observed=%b expected=%b", t, o1, e1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
